// File: rtl/modcnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modcnt_pkg
// Brief    : Shared constants and width helper for param_modulo_counter.
// Revision : 1.0 - initial release
// ============================================================================
package modcnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int WRAP_CNT_W = 16;

  // Number of bits needed to hold values 0..value-1 (minimum 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : modcnt_pkg
`default_nettype wire

// File: rtl/modcnt_next.sv
`default_nettype none
// ============================================================================
// Module   : modcnt_next
// Brief    : Combinational next-count and terminal-count calculator.
// Revision : 1.0 - initial release
// ============================================================================
module modcnt_next
  import modcnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             tc
);

  // One spare bit so MODULUS == 2**WIDTH still compares cleanly.
  localparam int c_cw = ((clog2(MODULUS) > WIDTH) ? clog2(MODULUS) : WIDTH) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(MODULUS - 1);

  logic [c_cw-1:0] w_cnt_ext;
  logic [c_cw-1:0] w_load_ext;
  logic            w_at_last;
  logic            w_at_zero;
  logic            w_term;

  always_comb begin
    w_cnt_ext  = c_cw'(count);
    w_load_ext = c_cw'(load_val);
    w_at_last  = (w_cnt_ext == c_last);
    w_at_zero  = (count == '0);
    w_term     = (dir == DIR_DOWN) ? w_at_zero : w_at_last;
    tc         = en & ~clr & ~load & w_term;

    next_count = count;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = (w_load_ext > c_last) ? WIDTH'(c_last) : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        next_count = w_at_last ? '0 : WIDTH'(w_cnt_ext + 1'b1);
      end else begin
        next_count = w_at_zero ? WIDTH'(c_last) : WIDTH'(w_cnt_ext - 1'b1);
      end
    end
  end

endmodule : modcnt_next
`default_nettype wire

// File: rtl/param_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_modulo_counter
// Brief    : Modulo-N up/down counter with tc strobe and divide-by-2N output.
//            Optional wrap counter output enabled by MODCNT_WRAP_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module param_modulo_counter
  import modcnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 6,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
`ifdef MODCNT_WRAP_COUNT_EN
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
`endif
  output logic             div_out
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("param_modulo_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
    $error("param_modulo_counter: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_div;
  logic [WIDTH-1:0] w_next_count;
  logic             w_tc;

  modcnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (r_count),
    .dir        (dir),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .next_count (w_next_count),
    .tc         (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= WIDTH'(RESET_VAL);
      r_div   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      if (w_tc) begin
        r_div <= ~r_div;
      end
    end
  end

`ifdef MODCNT_WRAP_COUNT_EN
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap_cnt <= '0;
    end else if (clr) begin
      r_wrap_cnt <= '0;
    end else if (w_tc && (r_wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
      r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

  assign count   = r_count;
  assign tc      = w_tc;
  assign div_out = r_div;

endmodule : param_modulo_counter
`default_nettype wire

// File: tb/tb_param_modulo_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_modulo_counter
// Brief    : Three counter variants (mod-6, mod-10, mod-6 reset-to-2) driven in
//            lock-step against a behavioural model and an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_modulo_counter;

  localparam int N_DUT = 3;
  localparam int MODS [N_DUT] = '{6, 10, 6};
  localparam int RVALS[N_DUT] = '{0, 0, 2};

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0]      load_val = 4'd0;
  logic [2:0][3:0] cnt;
  logic [2:0]      tc;
  logic [2:0]      div;
`ifdef MODCNT_WRAP_COUNT_EN
  logic [2:0][15:0] wcnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int   m_cnt[N_DUT];
  logic m_div[N_DUT];

  typedef struct {
    int   idx;
    int   cnt;
    logic div;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    param_modulo_counter #(
      .WIDTH     (4),
      .MODULUS   (MODS[g]),
      .RESET_VAL (RVALS[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .dir      (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .count    (cnt[g]),
      .tc       (tc[g]),
`ifdef MODCNT_WRAP_COUNT_EN
      .wrap_cnt (wcnt[g]),
`endif
      .div_out  (div[g])
    );
  end

  function automatic logic model_tc(input int m, input int c);
    return en && !clr && !load && (dir ? (c == 0) : (c == m - 1));
  endfunction

  function automatic int model_next(input int m, input int c);
    if (clr) return 0;
    if (load) return (int'(load_val) < m) ? int'(load_val) : m - 1;
    if (!en) return c;
    if (dir) return (c == 0) ? m - 1 : c - 1;
    return (c == m - 1) ? 0 : c + 1;
  endfunction

  // One clock: drive at negedge, check tc, queue next state, check after edge.
  task automatic step(input logic i_en, input logic i_dir, input logic i_clr,
                      input logic i_load, input logic [3:0] i_lv);
    exp_t e;
    logic exp_tc;
    logic [3:0] exp_c;
    @(negedge clk);
    en = i_en; dir = i_dir; clr = i_clr; load = i_load; load_val = i_lv;
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      exp_tc = model_tc(MODS[d], m_cnt[d]);
      n_tests++;
      if (tc[d] !== exp_tc) begin
        n_fail++;
        $display("FAIL tc dut%0d: got %b want %b (count %0d)", d, tc[d], exp_tc, m_cnt[d]);
      end
      if (exp_tc) m_div[d] = ~m_div[d];
      m_cnt[d] = model_next(MODS[d], m_cnt[d]);
      e.idx = d; e.cnt = m_cnt[d]; e.div = m_div[d];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_c = 4'(e.cnt);
      n_tests++;
      if (cnt[e.idx] !== exp_c || div[e.idx] !== e.div) begin
        n_fail++;
        $display("FAIL count/div dut%0d: got %0d/%b want %0d/%b",
                 e.idx, cnt[e.idx], div[e.idx], exp_c, e.div);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [3:0] exp_c;
    for (int d = 0; d < N_DUT; d++) begin
      exp_c = 4'(RVALS[d]);
      n_tests++;
      if (cnt[d] !== exp_c || div[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s dut%0d: got %0d/%b want %0d/0", tag, d, cnt[d], div[d], exp_c);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    en = 1'b1; dir = 1'b0; clr = 1'b0; load = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_state("reset_async");
    @(posedge clk);
    #1;
    check_reset_state("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    for (int d = 0; d < N_DUT; d++) begin
      m_cnt[d] = RVALS[d];
      m_div[d] = 1'b0;
    end
  endtask

  task automatic test_up_count();
    int   n_tog;
    int   tog_at[2];
    logic prev;
    test_reset();
    n_tog = 0;
    prev  = div[0];
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      if (div[0] !== prev) begin
        if (n_tog < 2) tog_at[n_tog] = i;
        n_tog++;
        prev = div[0];
      end
    end
    n_tests++;
    if (n_tog != 2 || tog_at[0] != 6 || tog_at[1] != 12) begin
      n_fail++;
      $display("FAIL div_period: toggles %0d at %0d,%0d want 2 at 6,12",
               n_tog, tog_at[0], tog_at[1]);
    end
  endtask

  task automatic test_down_count();
    test_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_load();
    test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd13);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_clr_load();
    test_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_async_reset();
    test_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    en = 1'b1; load = 1'b1; load_val = 4'd4; clr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_mid");
    @(posedge clk);
    #1;
    check_reset_state("async_hold");
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0;
    en = 1'b0;
    for (int d = 0; d < N_DUT; d++) begin
      m_cnt[d] = RVALS[d];
      m_div[d] = 1'b0;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_random_mix();
    logic r_dir;
    r_dir = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) r_dir = ~r_dir;
      step($urandom_range(3) != 0, r_dir, $urandom_range(19) == 0,
           $urandom_range(11) == 0, 4'($urandom_range(15)));
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_clr_load();
    test_async_reset();
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_param_modulo_counter
`default_nettype wire
